ifft_4p_seq: RTL and testbench
==============================

# ifft_4p_seq

Sequential 4-point inverse FFT for the fixed-point FFT datapath: collects one frame of four complex frequency-domain samples over a valid/ready stream, runs two radix-2 butterfly stages over two cycles, then streams four time-domain samples out in natural order. It is the return path of the 4-point FFT. It uses the same symmetric-saturation arithmetic so that a forward/inverse round trip stays inside one numeric format.

## Interface
Parameters:
- DATAWIDTH, 16, width of each signed real/imag component (two's complement).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept an input sample.
- s_real, s_imag  in  DATAWIDTH each  input sample X[k]; k is implied by arrival order 0..3.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accepts the output sample.
- m_real, m_imag  out  DATAWIDTH each  output sample x[n]; n is implied by departure order 0..3.
- m_last  out  1  high with output beat n=3.

## Operation
- States:
  - COLLECT: s_ready=1. Each s_valid&&s_ready beat stores X[cnt] and increments the 2-bit cnt. The beat with cnt=3 moves the block to ST1.
  - ST1: one cycle. Computes and registers stage 1, then moves to ST2.
  - ST2: one cycle. Computes and registers stage 2, then moves to EMIT.
  - EMIT: m_valid=1. Each m_valid&&m_ready beat advances ocnt. The beat with ocnt=3 moves the block to COLLECT and clears cnt and ocnt.
- Stage 1:
  - A0=X0+X2, A1=X0−X2, B0=X1+X3.
  - B1 is (X1−X3)·j, computed as B1.re=X3.im−X1.im and B1.im=X1.re−X3.re. No negation is used, so there is no −2^(DATAWIDTH−1) overflow.
- Stage 2: x0=A0+B0, x1=A1+B1, x2=A0−B0, x3=A1−B1.
- Arithmetic rules:
  - Every add/sub is done at DATAWIDTH+1 bits, optionally scaled (see Configuration), then symmetric-saturated to DATAWIDTH bits.
  - The saturation range is [−(2^(DATAWIDTH−1)−1), 2^(DATAWIDTH−1)−1]. The most negative code is never produced.
- s_ready=0 in ST1, ST2 and EMIT. Input is never accepted while output is pending.
- Output data is held stable while m_valid=1 and m_ready=0.

## Timing
- Reset values:
  - s_ready=1, m_valid=0, m_last=0, m_real=0, m_imag=0.
  - state=COLLECT, cnt=0, ocnt=0. All sample registers are 0.
- Reset asserted mid-frame, in any state, aborts the frame immediately (asynchronously). Partially collected or unsent samples are discarded.
- Latency: if X[3] is accepted on edge E, stage 1 registers at E+1, stage 2 registers at E+2, and m_valid is high from E+2 with x0.
- Throughput: minimum 10 cycles per frame (4 in, 2 compute, 4 out). s_ready rises in the cycle after the x3 handshake edge.
- m_valid with m_ready held high yields 4 consecutive beats. Back-pressure stalls indefinitely with no loss.
- s_valid is ignored outside COLLECT. m_ready is ignored outside EMIT.

## Configuration
- IFFT4_SCALE_EN defined:
  - Every (DATAWIDTH+1)-bit stage result is arithmetic-shifted right by 1 (rounds toward −∞) before saturation.
  - Output is the true IFFT (1/4)·Σ X[k]·W^(−nk). Saturation then affects only the −2^(DATAWIDTH−1) code.
- IFFT4_SCALE_EN undefined:
  - No shift; output is the unscaled Σ X[k]·W^(−nk).
  - Results are symmetric-saturated at each stage.

## Structure
- Shared package `fft_pkg`:
  - cplx_t: struct of signed DATAWIDTH real/imag.
  - The state enum {COLLECT, ST1, ST2, EMIT}.
  - The parameterized symmetric-saturation function, shared with the forward FFT.
- One sub-module `bfly_sc`: combinational two-input add/sub butterfly with the IFFT4_SCALE_EN shift plus saturation. It is instantiated twice per stage and time-shared across ST1/ST2.

## Test plan
- Impulse, real X=[256,0,0,0], m_ready=1 → scaled: x=[64,64,64,64]; unscaled: [256,256,256,256]; all imag 0; m_last only on beat 3.
- Rotation, X=[0,256,0,0] → scaled: x0=64, x1=j64, x2=−64, x3=−j64; unscaled: ±256 / ±j256 at the same positions.
- Saturation, X all 32767+j0 → x0=32767, x1=x2=x3=0 in both builds; no −32768 ever output. Also X0=−1 scaled → x0=−1.
- Back-pressure: m_ready low for 5 cycles on beat 1 → m_real/m_imag stable, s_ready=0 throughout; all 4 beats delivered in order afterwards, with s_valid pulses during EMIT ignored.
- Reset mid-EMIT: rst_n low during beat 2 → m_valid=0 and s_ready=1 immediately; the next impulse frame yields the correct [64,64,64,64].
- Back-to-back frames with s_valid=1 and m_ready=1 continuously → 10-cycle frame period; first m_valid exactly 2 edges after the X[3] acceptance edge.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared types and arithmetic helpers for the fixed-point FFT
//               datapath (forward 4-point FFT and inverse ifft_4p_seq).
//               - cplx_t      : complex sample with signed real/imag parts
//               - fft_state_t : sequencer states COLLECT/ST1/ST2/EMIT
//               - sat_sym()   : symmetric saturation to a given width
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int FFT_DATAWIDTH = 16;

    // Working width of the saturation helper; callers sign-extend into it.
    localparam int SAT_W = 33;

    typedef struct packed {
        logic signed [FFT_DATAWIDTH-1:0] re;
        logic signed [FFT_DATAWIDTH-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ST1     = 2'd1,
        ST2     = 2'd2,
        EMIT    = 2'd3
    } fft_state_t;

    // Clamp v to [-(2^(width-1)-1), 2^(width-1)-1]. The most negative code
    // of the target width is never returned, so negating a result is safe.
    function automatic logic signed [SAT_W-1:0] sat_sym(
        input logic signed [SAT_W-1:0] v,
        input int                      width
    );
        logic signed [SAT_W-1:0] lim;
        lim = (SAT_W'(1) <<< (width - 1)) - SAT_W'(1);
        if (v > lim) begin
            return lim;
        end else if (v < -lim) begin
            return -lim;
        end else begin
            return v;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifft_4p_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : ifft_4p_seq_if
// Description : Stream bundle for ifft_4p_seq.
//               Input side : s_valid, s_ready, s_real, s_imag  (X[k], k=0..3)
//               Output side: m_valid, m_ready, m_real, m_imag, m_last
//               modport slave  - the transform block
//               modport master - the environment driving/consuming it
// Revision    : 1.0 - initial release
// ============================================================================
interface ifft_4p_seq_if #(
    parameter int DATAWIDTH = 16
);
    logic                        s_valid;
    logic                        s_ready;
    logic signed [DATAWIDTH-1:0] s_real;
    logic signed [DATAWIDTH-1:0] s_imag;
    logic                        m_valid;
    logic                        m_ready;
    logic signed [DATAWIDTH-1:0] m_real;
    logic signed [DATAWIDTH-1:0] m_imag;
    logic                        m_last;

    modport slave (
        input  s_valid, s_real, s_imag, m_ready,
        output s_ready, m_valid, m_real, m_imag, m_last
    );

    modport master (
        output s_valid, s_real, s_imag, m_ready,
        input  s_ready, m_valid, m_real, m_imag, m_last
    );
endinterface
`default_nettype wire

// File: rtl/bfly_sc.sv
`default_nettype none
// ============================================================================
// Module      : bfly_sc
// Description : Combinational radix-2 butterfly with optional scaling and
//               symmetric saturation.
//                 sum = a + b
//                 dif = a - b            (rot = 0)
//                 dif = j * (a - b)      (rot = 1)
//               j*(a-b) is formed as re = b.im - a.im, im = a.re - b.re, so
//               no negation (and no most-negative overflow) is involved.
//               Macro IFFT4_SCALE_EN: results are arithmetic-shifted right by
//               one before saturation.
// Ports       : rot, a_re/a_im, b_re/b_im in; sum_re/sum_im, dif_re/dif_im out
// Revision    : 1.0 - initial release
// ============================================================================
module bfly_sc
    import fft_pkg::*;
#(
    parameter int DATAWIDTH = 16
) (
    input  logic                        rot,
    input  logic signed [DATAWIDTH-1:0] a_re,
    input  logic signed [DATAWIDTH-1:0] a_im,
    input  logic signed [DATAWIDTH-1:0] b_re,
    input  logic signed [DATAWIDTH-1:0] b_im,
    output logic signed [DATAWIDTH-1:0] sum_re,
    output logic signed [DATAWIDTH-1:0] sum_im,
    output logic signed [DATAWIDTH-1:0] dif_re,
    output logic signed [DATAWIDTH-1:0] dif_im
);

    localparam int EW = DATAWIDTH + 1;

`ifdef IFFT4_SCALE_EN
    localparam int C_SHIFT = 1;
`else
    localparam int C_SHIFT = 0;
`endif

    logic signed [EW-1:0] w_a_re, w_a_im, w_b_re, w_b_im;
    logic signed [EW-1:0] w_sum_re, w_sum_im, w_dif_re, w_dif_im;
    logic signed [EW-1:0] w_sum_re_s, w_sum_im_s, w_dif_re_s, w_dif_im_s;

    assign w_a_re = EW'(a_re);
    assign w_a_im = EW'(a_im);
    assign w_b_re = EW'(b_re);
    assign w_b_im = EW'(b_im);

    assign w_sum_re = w_a_re + w_b_re;
    assign w_sum_im = w_a_im + w_b_im;
    assign w_dif_re = rot ? (w_b_im - w_a_im) : (w_a_re - w_b_re);
    assign w_dif_im = rot ? (w_a_re - w_b_re) : (w_a_im - w_b_im);

    // Arithmetic shift rounds toward minus infinity.
    assign w_sum_re_s = w_sum_re >>> C_SHIFT;
    assign w_sum_im_s = w_sum_im >>> C_SHIFT;
    assign w_dif_re_s = w_dif_re >>> C_SHIFT;
    assign w_dif_im_s = w_dif_im >>> C_SHIFT;

    assign sum_re = DATAWIDTH'(sat_sym(SAT_W'(w_sum_re_s), DATAWIDTH));
    assign sum_im = DATAWIDTH'(sat_sym(SAT_W'(w_sum_im_s), DATAWIDTH));
    assign dif_re = DATAWIDTH'(sat_sym(SAT_W'(w_dif_re_s), DATAWIDTH));
    assign dif_im = DATAWIDTH'(sat_sym(SAT_W'(w_dif_im_s), DATAWIDTH));

endmodule
`default_nettype wire

// File: rtl/ifft_4p_seq.sv
`default_nettype none
// ============================================================================
// Module      : ifft_4p_seq
// Description : Sequential 4-point inverse FFT. Collects X[0..3] over the
//               input stream, runs two butterfly stages (one cycle each) on
//               two shared bfly_sc instances, then streams x[0..3] out in
//               natural order with m_last on x[3].
//               Macro IFFT4_SCALE_EN: divide by two per stage (true IFFT).
// Ports       : clk, rst_n (async, active-low),
//               bus (ifft_4p_seq_if.slave): s_valid/s_ready/s_real/s_imag,
//                                           m_valid/m_ready/m_real/m_imag/m_last
// Revision    : 1.0 - initial release
// ============================================================================
module ifft_4p_seq
    import fft_pkg::*;
#(
    parameter int DATAWIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    ifft_4p_seq_if.slave     bus
);

    fft_state_t r_state, w_state_nxt;
    logic [1:0] r_cnt, r_ocnt;
    logic       w_s_fire, w_m_fire;

    // Sample store. Slot use per phase:
    //   COLLECT : X0 X1 X2 X3
    //   after ST1: A0 B0 A1 B1
    //   after ST2: x0 x1 x2 x3
    // With that layout both stages write back through the same mapping.
    logic signed [DATAWIDTH-1:0] r_re [0:3];
    logic signed [DATAWIDTH-1:0] r_im [0:3];

    logic                        w_rot;
    logic signed [DATAWIDTH-1:0] w_b0_bre, w_b0_bim;
    logic signed [DATAWIDTH-1:0] w_b1_are, w_b1_aim;
    logic signed [DATAWIDTH-1:0] w_b0_sre, w_b0_sim, w_b0_dre, w_b0_dim;
    logic signed [DATAWIDTH-1:0] w_b1_sre, w_b1_sim, w_b1_dre, w_b1_dim;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake qualification
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_s_fire    = 1'b0;
        w_m_fire    = 1'b0;
        case (r_state)
            COLLECT: begin
                if (bus.s_valid) begin
                    w_s_fire = 1'b1;
                    if (r_cnt == 2'd3) begin
                        w_state_nxt = ST1;
                    end
                end
            end
            ST1:     w_state_nxt = ST2;
            ST2:     w_state_nxt = EMIT;
            EMIT: begin
                if (bus.m_ready) begin
                    w_m_fire = 1'b1;
                    if (r_ocnt == 2'd3) begin
                        w_state_nxt = COLLECT;
                    end
                end
            end
            default: w_state_nxt = COLLECT;
        endcase
    end

    // ------------------------------------------------------------------
    // Butterfly operand selection
    //   ST1: bfly0 (X0, X2) -> A0/A1, bfly1 (X1, X3) rotated -> B0/B1
    //   ST2: bfly0 (A0, B0) -> x0/x2, bfly1 (A1, B1)          -> x1/x3
    // ------------------------------------------------------------------
    always_comb begin
        w_rot    = (r_state == ST1);
        w_b0_bre = r_re[2];
        w_b0_bim = r_im[2];
        w_b1_are = r_re[1];
        w_b1_aim = r_im[1];
        if (r_state == ST2) begin
            w_b0_bre = r_re[1];
            w_b0_bim = r_im[1];
            w_b1_are = r_re[2];
            w_b1_aim = r_im[2];
        end
    end

    bfly_sc #(.DATAWIDTH(DATAWIDTH)) u_bfly0 (
        .rot    (1'b0),
        .a_re   (r_re[0]),
        .a_im   (r_im[0]),
        .b_re   (w_b0_bre),
        .b_im   (w_b0_bim),
        .sum_re (w_b0_sre),
        .sum_im (w_b0_sim),
        .dif_re (w_b0_dre),
        .dif_im (w_b0_dim)
    );

    bfly_sc #(.DATAWIDTH(DATAWIDTH)) u_bfly1 (
        .rot    (w_rot),
        .a_re   (w_b1_are),
        .a_im   (w_b1_aim),
        .b_re   (r_re[3]),
        .b_im   (r_im[3]),
        .sum_re (w_b1_sre),
        .sum_im (w_b1_sim),
        .dif_re (w_b1_dre),
        .dif_im (w_b1_dim)
    );

    // ------------------------------------------------------------------
    // Sample store and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 2'd0;
            r_ocnt <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_re[i] <= '0;
                r_im[i] <= '0;
            end
        end else begin
            if (w_s_fire) begin
                r_re[r_cnt] <= bus.s_real;
                r_im[r_cnt] <= bus.s_imag;
                r_cnt       <= r_cnt + 2'd1;
            end
            if ((r_state == ST1) || (r_state == ST2)) begin
                r_re[0] <= w_b0_sre;
                r_im[0] <= w_b0_sim;
                r_re[2] <= w_b0_dre;
                r_im[2] <= w_b0_dim;
                r_re[1] <= w_b1_sre;
                r_im[1] <= w_b1_sim;
                r_re[3] <= w_b1_dre;
                r_im[3] <= w_b1_dim;
            end
            if (w_m_fire) begin
                if (r_ocnt == 2'd3) begin
                    r_ocnt <= 2'd0;
                    r_cnt  <= 2'd0;
                end else begin
                    r_ocnt <= r_ocnt + 2'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state so reset acts on them immediately.
    // ------------------------------------------------------------------
    assign bus.s_ready = (r_state == COLLECT);
    assign bus.m_valid = (r_state == EMIT);
    assign bus.m_last  = (r_state == EMIT) && (r_ocnt == 2'd3);
    assign bus.m_real  = r_re[r_ocnt];
    assign bus.m_imag  = r_im[r_ocnt];

endmodule
`default_nettype wire

// File: tb/tb_ifft_4p_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ifft_4p_seq
// Description : Directed self-checking bench for ifft_4p_seq. Expected
//               values follow the IFFT4_SCALE_EN build selection.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifft_4p_seq;
    import fft_pkg::*;

    localparam int DATAWIDTH = 16;
    localparam int MAX_WAIT  = 50;

`ifdef IFFT4_SCALE_EN
    localparam bit SCALED = 1'b1;
`else
    localparam bit SCALED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ifft_4p_seq_if #(.DATAWIDTH(DATAWIDTH)) bus ();

    ifft_4p_seq #(.DATAWIDTH(DATAWIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc      = 0;
    int    t_x3_acc;
    int    t_prev_x3;
    int    t_first_valid;
    cplx_t vec_in  [4];
    cplx_t vec_exp [4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic set_in(input int k, input int re, input int im);
        vec_in[k].re = DATAWIDTH'(re);
        vec_in[k].im = DATAWIDTH'(im);
    endtask

    task automatic set_exp(input int k, input int re, input int im);
        vec_exp[k].re = DATAWIDTH'(re);
        vec_exp[k].im = DATAWIDTH'(im);
    endtask

    // Called #1 after a clock edge; leaves s_valid high after X3 so that
    // the block sees (and must ignore) input activity outside COLLECT.
    task automatic send_frame();
        int waited;
        for (int k = 0; k < 4; k++) begin
            bus.s_valid = 1'b1;
            bus.s_real  = vec_in[k].re;
            bus.s_imag  = vec_in[k].im;
            waited = 0;
            while (!bus.s_ready && waited < MAX_WAIT) begin
                @(posedge clk); #1;
                waited++;
            end
            if (!bus.s_ready) begin
                check_val("s_ready_timeout", 0, 1);
                return;
            end
            @(posedge clk); #1;
            if (k == 3) t_x3_acc = cyc;
        end
    endtask

    task automatic recv_frame(input string name, input int stall_beat, input int abort_beat);
        int waited;
        bus.m_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            waited = 0;
            while (!bus.m_valid && waited < MAX_WAIT) begin
                @(posedge clk); #1;
                waited++;
            end
            if (!bus.m_valid) begin
                check_val({name, "_m_valid_timeout"}, 0, 1);
                bus.s_valid = 1'b0;
                return;
            end
            if (n == 0) t_first_valid = cyc;
            if (n == abort_beat) begin
                #2 rst_n = 1'b0;
                #1;
                check_val({name, "_rst_m_valid"}, bus.m_valid, 0);
                check_val({name, "_rst_s_ready"}, bus.s_ready, 1);
                check_val({name, "_rst_m_last"},  bus.m_last,  0);
                bus.s_valid = 1'b0;
                rst_n = 1'b1;
                return;
            end
            check_val($sformatf("%s_x%0d_re", name, n), bus.m_real, vec_exp[n].re);
            check_val($sformatf("%s_x%0d_im", name, n), bus.m_imag, vec_exp[n].im);
            check_val($sformatf("%s_x%0d_last", name, n), bus.m_last, (n == 3));
            if (n == stall_beat) begin
                bus.m_ready = 1'b0;
                repeat (5) begin
                    bus.s_valid = 1'b1;
                    bus.s_real  = DATAWIDTH'($urandom);
                    bus.s_imag  = DATAWIDTH'($urandom);
                    @(posedge clk); #1;
                    check_val($sformatf("%s_stall_re", name), bus.m_real, vec_exp[n].re);
                    check_val($sformatf("%s_stall_im", name), bus.m_imag, vec_exp[n].im);
                    check_val($sformatf("%s_stall_valid", name), bus.m_valid, 1);
                    check_val($sformatf("%s_stall_s_ready", name), bus.s_ready, 0);
                end
                bus.m_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        check_val({name, "_done_m_valid"}, bus.m_valid, 0);
        check_val({name, "_done_s_ready"}, bus.s_ready, 1);
    endtask

    task automatic load_impulse();
        set_in(0, 256, 0); set_in(1, 0, 0); set_in(2, 0, 0); set_in(3, 0, 0);
        for (int n = 0; n < 4; n++) set_exp(n, SCALED ? 64 : 256, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_real  = '0;
        bus.s_imag  = '0;
        bus.m_ready = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_s_ready", bus.s_ready, 1);
        check_val("rst_m_valid", bus.m_valid, 0);
        check_val("rst_m_last",  bus.m_last,  0);
        check_val("rst_m_real",  bus.m_real,  0);
        check_val("rst_m_imag",  bus.m_imag,  0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Impulse, with latency check
        load_impulse();
        send_frame();
        recv_frame("imp", -1, -1);
        check_val("latency", t_first_valid - t_x3_acc, 2);
        t_prev_x3 = t_x3_acc;

        // Rotation, sent immediately: frame period check
        set_in(0, 0, 0); set_in(1, 256, 0); set_in(2, 0, 0); set_in(3, 0, 0);
        set_exp(0, SCALED ? 64 : 256, 0);
        set_exp(1, 0, SCALED ? 64 : 256);
        set_exp(2, SCALED ? -64 : -256, 0);
        set_exp(3, 0, SCALED ? -64 : -256);
        send_frame();
        check_val("frame_period", t_x3_acc - t_prev_x3, 10);
        recv_frame("rot", -1, -1);

        // Positive saturation
        for (int k = 0; k < 4; k++) set_in(k, 32767, 0);
        set_exp(0, 32767, 0); set_exp(1, 0, 0); set_exp(2, 0, 0); set_exp(3, 0, 0);
        send_frame();
        recv_frame("satp", -1, -1);

        // X0 = -1: floor rounding keeps -1 at every output
        set_in(0, -1, 0); set_in(1, 0, 0); set_in(2, 0, 0); set_in(3, 0, 0);
        for (int n = 0; n < 4; n++) set_exp(n, -1, 0);
        send_frame();
        recv_frame("neg1", -1, -1);

        // Most-negative inputs: -32768 must never come out
        set_in(0, -32768, 0); set_in(1, 0, 0); set_in(2, -32768, 0); set_in(3, 0, 0);
        set_exp(0, SCALED ? -16384 : -32767, 0);
        set_exp(1, 0, 0);
        set_exp(2, SCALED ? -16384 : -32767, 0);
        set_exp(3, 0, 0);
        send_frame();
        recv_frame("satn", -1, -1);

        // General complex frame
        set_in(0, 100, 20); set_in(1, 40, -8); set_in(2, -60, 4); set_in(3, 12, 16);
        set_exp(0, SCALED ? 23 : 92,  SCALED ? 8 : 32);
        set_exp(1, SCALED ? 46 : 184, SCALED ? 11 : 44);
        set_exp(2, SCALED ? -3 : -12, SCALED ? 4 : 16);
        set_exp(3, SCALED ? 34 : 136, SCALED ? -3 : -12);
        send_frame();
        recv_frame("cplx", -1, -1);

        // Back-pressure on beat 1 with junk input during EMIT
        load_impulse();
        send_frame();
        recv_frame("bp", 1, -1);

        // Reset during beat 2, then a clean impulse frame
        load_impulse();
        send_frame();
        recv_frame("abort", -1, 2);
        @(posedge clk); #1;
        load_impulse();
        send_frame();
        recv_frame("post", -1, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
